// File: rtl/mem_arbiter_pkg.sv
// Shared memory-access constants for the arbiter and its users.
// Width codes are the load/store size encodings seen on every memory port.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        memWidth1    = 2'd0,
        memWidth2    = 2'd1,
        memWidth4    = 2'd2,
        memWidthRsvd = 2'd3
    } memWidth_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto one memory port, A = CPU data, B = DMA.
// One transaction in flight; a timeout completes a silent access with an error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_width,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    output logic        a_exc,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_width,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic        b_exc,
    output logic        m_req,
    output logic        m_we,
    output logic [1:0]  m_width,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    input  logic        m_exc,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e      state;
    state_e      stateNext;
    logic [7:0]  cnt;
    logic        lastGrant;
    logic        grantQ;
    logic        weQ;
    memWidth_e   widthQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [31:0] rdataQ;
    logic        excQ;
    logic        winner;
    logic        timeout;

    // On a tie the requester not served last wins; otherwise whoever asks.
    always_comb begin
        winner  = (a_req && b_req) ? ~lastGrant : b_req;
        timeout = (cnt + 8'd1) == TimeoutCnt;
    end

    assign grant = grantQ;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and all port outputs.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_width   = 2'd0;
        m_addr    = 32'd0;
        m_wdata   = 32'd0;
        a_ack     = 1'b0;
        a_rdata   = 32'd0;
        a_exc     = 1'b0;
        b_ack     = 1'b0;
        b_rdata   = 32'd0;
        b_exc     = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                busy    = 1'b1;
                m_req   = 1'b1;
                m_we    = weQ;
                m_width = widthQ;
                m_addr  = addrQ;
                m_wdata = wdataQ;
                if (m_ack || timeout) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                stateNext = IDLE;
                if (grantQ) begin
                    b_ack   = 1'b1;
                    b_rdata = rdataQ;
                    b_exc   = excQ;
                end else begin
                    a_ack   = 1'b1;
                    a_rdata = rdataQ;
                    a_exc   = excQ;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Request latching, wait counter and completion capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= 8'd0;
            lastGrant <= 1'b1;
            grantQ    <= 1'b0;
            weQ       <= 1'b0;
            widthQ    <= memWidth1;
            addrQ     <= 32'd0;
            wdataQ    <= 32'd0;
            rdataQ    <= 32'd0;
            excQ      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grantQ <= winner;
                        cnt    <= 8'd0;
                        weQ    <= winner ? b_we : a_we;
                        widthQ <= memWidth_e'(winner ? b_width : a_width);
                        addrQ  <= winner ? b_addr : a_addr;
                        wdataQ <= winner ? b_wdata : a_wdata;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (m_ack) begin
                        rdataQ <= m_rdata;
                        excQ   <= m_exc;
                    end else if (timeout) begin
                        rdataQ <= 32'd0;
                        excQ   <= 1'b1;
                    end
                end
                DONE: begin
                    lastGrant <= grantQ;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles waited for m_ack before bus-error completion (1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports a_req/b_req  input  1  requester A (CPU data port) / B (DMA port) transaction request.
REQ-005 SHALL have ports a_we/b_we  input  1  write enable; a_width/b_width  input  2  memWidth4/2/1 code; a_addr/b_addr  input  32  byte address; a_wdata/b_wdata  input  32  store data.
REQ-006 SHALL have ports a_ack/b_ack  output  1  one-cycle completion pulse; a_rdata/b_rdata  output  32  load data; a_exc/b_exc  output  1  exception, valid with ack.
REQ-007 SHALL have ports m_req  output  1; m_we  output  1; m_width  output  2; m_addr  output  32; m_wdata  output  32; shared memory port request fields.
REQ-008 SHALL have ports m_ack  input  1; m_rdata  input  32; m_exc  input  1; memory completion, rdata and address exception.
REQ-009 SHALL have ports busy  output  1  FSM not IDLE; grant  output  1  0=A, 1=B, last or current owner.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 IDLE: if no req, stay; if only one req, grant it; if both, grant the requester not served last (last_grant), then latch we/width/addr/wdata of winner and enter BUSY.
REQ-012 BUSY: m_req=1 and m_* driven from latched fields, constant for whole state; requester inputs ignored.
REQ-013 BUSY: on m_ack=1, capture m_rdata and m_exc, enter DONE.
REQ-014 BUSY: cycle counter starts at 0 on entry; if counter reaches TIMEOUT with no m_ack, capture rdata=0, exc=1, enter DONE; m_ack in the same cycle as timeout takes precedence.
REQ-015 DONE: assert granted x_ack=1 for exactly one cycle with captured x_rdata/x_exc, update last_grant, return to IDLE.
REQ-016 x_rdata and x_exc SHALL be 0 whenever x_ack=0; the other requester's ack SHALL remain 0.
REQ-017 m_req and all m_* outputs SHALL be 0 outside BUSY.
REQ-018 Latency: req sampled at edge 0, m_req high cycle 1, m_ack in cycle k>=1 gives x_ack in cycle k+1; minimum 2 cycles.
REQ-019 No abort: requester dropping req during BUSY does not end the transaction; ack still pulses.
REQ-020 Requester still asserting req in its DONE cycle is re-sampled only in the following IDLE, where round-robin then favours the other requester if it is pending.
REQ-021 m_width, m_we, m_addr passed unmodified; alignment/range checks are the memory's job, reported via m_exc.

Reset
REQ-022 On clk edge with reset=0: state=IDLE, counter=0, last_grant=1 (A wins first tie), grant=0, latched fields and captured data=0.
REQ-023 After reset edge all outputs SHALL be 0; reset mid-BUSY drops m_req next cycle and no ack is produced for the aborted transaction.

Structure
REQ-024 memWidth4/2/1 codes SHALL come from the shared constants file; FSM state encodings SHALL be local.
REQ-025 Single module, no sub-modules; timeout counter 8 bits wide.

Verification
REQ-026 A-only write, addr 0x100, wdata 0xDEADBEEF, m_ack in cycle 1 -> m_* fields match, a_ack in cycle 2, b_ack=0.
REQ-027 A and B both request at cycle 0 after reset, each held until ack -> A served first, then B; grant toggles 0 then 1.
REQ-028 B load with m_ack delayed 5 cycles, m_rdata=0x12345678 -> b_ack 1 cycle after m_ack, b_rdata=0x12345678, b_exc=0.
REQ-029 m_ack never asserted, TIMEOUT=15 -> a_ack with a_exc=1, a_rdata=0 after 15 BUSY cycles; m_exc=1 on ack case -> a_exc=1.
REQ-030 reset=0 asserted mid-BUSY -> next cycle m_req=0, busy=0, no ack; fresh A request afterwards completes normally.
REQ-031 Both requesters held continuously for 8 transactions -> strict alternation A,B,A,B; neither waits more than one transaction.
